wb_gcd_initiator: RTL and testbench
===================================

// Module: wb_gcd_initiator
// PURPOSE
//  Wishbone classic initiator (master) that drives the GCD user-project slave.
//  Accepts operand pairs on a valid/ready request stream and performs one write
//  transaction carrying {a,b}, one idle gap cycle, then one read transaction
//  returning the GCD. The result, or a timeout error, is presented on a
//  valid/ready response stream.
//  Sits between on-chip control logic and the user_proj_example Wishbone port.
// PARAMETERS
//  GCD_ADDR        32'h3000_0000  wbm_adr_o value for both write and read
//  TIMEOUT_CYCLES  255            max cycles stb held waiting for ack (>=1)
// PORTS
//  clk         in   1   clock
//  reset       in   1   synchronous, active-low reset
//  req_val     in   1   operand pair valid
//  req_rdy     out  1   initiator idle, can accept request
//  req_a       in   16  operand a
//  req_b       in   16  operand b
//  resp_val    out  1   result valid
//  resp_rdy    in   1   consumer accepts result
//  resp_c      out  16  GCD result (0 on error)
//  resp_err    out  1   1 = ack timeout, result invalid
//  wbm_cyc_o   out  1   bus cycle
//  wbm_stb_o   out  1   strobe
//  wbm_we_o    out  1   1 = write
//  wbm_sel_o   out  4   byte selects, always 4'hF
//  wbm_adr_o   out  32  address, always GCD_ADDR
//  wbm_dat_o   out  32  write data {a[15:0], b[15:0]}
//  wbm_dat_i   in   32  read data, result in [15:0]
//  wbm_ack_i   in   1   slave acknowledge
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE; cyc/stb/we/resp_val/resp_err=0;
//    resp_c=0, dat_o=0, timeout counter=0. req_rdy=0 while reset is low.
//  - All Wishbone outputs and resp_* are registered. req_rdy = (state==IDLE) & reset.
//  - States: IDLE -> WR -> GAP -> RD -> RESP -> IDLE.
//  - IDLE: on req_val&req_rdy at edge N, latch dat_o={req_a,req_b}. Enter WR;
//    cyc=stb=we=1 from cycle N+1.
//  - WR: hold cyc/stb/we/dat_o stable until ack is sampled high. At that edge
//    drop cyc/stb/we and enter GAP.
//  - GAP: exactly one cycle with cyc=stb=0. Then enter RD with cyc=stb=1, we=0.
//  - RD: hold until ack. At the ack edge, capture resp_c=wbm_dat_i[15:0], set
//    resp_err=0, drop cyc/stb, set resp_val=1, enter RESP.
//  - Timeout: counter clears on entry to WR/RD and increments each cycle stb
//    is high without ack. When it reaches TIMEOUT_CYCLES-1 with no ack:
//    abort, drop cyc/stb/we next edge, resp_c=0, resp_err=1, resp_val=1,
//    enter RESP. The read is skipped on a write timeout.
//    An ack on the same edge as expiry counts as success.
//  - RESP: resp_val/resp_c/resp_err held stable until resp_rdy. On handshake
//    resp_val=0 and enter IDLE. A new request is accepted no earlier than the
//    cycle after the handshake.
//  - wbm_ack_i outside WR/RD is ignored, with no state change.
//  - Reset mid-transaction: cyc/stb drop at that edge; in-flight result is
//    discarded; no resp_val is issued.
//  - Minimum latency with a combinational-ack slave: accept N, write ack N+1,
//    GAP N+2, read ack N+3, resp_val high from N+4.
// TESTING
//  1. reset=0 for 10 cycles with random ack/dat_i -> cyc/stb/we/resp_val all 0;
//     req_rdy=1 the cycle after reset=1.
//  2. a=48, b=18; slave acks write after 2 wait cycles, read returns 6 ->
//     dat_o=32'h0030_0012, we=1 during write, one cyc=0 gap, resp_c=6, resp_err=0.
//  3. TIMEOUT_CYCLES=8, slave never acks -> stb high exactly 8 cycles;
//     resp_val=1, resp_err=1, resp_c=0; no read issued.
//  4. resp_rdy held low 5 cycles -> resp_val/resp_c stable and req_rdy=0
//     throughout; next request accepted only after the handshake.
//  5. reset=0 during RD wait -> cyc/stb=0 next edge, no resp_val; next request
//     completes normally.
//  6. 100 back-to-back random pairs vs. a GCD slave model, plus a spurious ack
//     in IDLE -> all results match, spurious ack ignored.

Source files
------------

// File: rtl/wb_gcd_initiator.sv
// Wishbone classic initiator for the GCD user-project slave.
// Takes an operand pair from a valid/ready request stream and writes {a,b}
// to the slave. It then leaves the bus idle for one cycle and reads the
// GCD back. The result, or an ack-timeout error, goes out on a valid/ready
// response stream.
module wb_gcd_initiator #(
    parameter logic [31:0] GCD_ADDR       = 32'h3000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        resp_val,
    input  logic        resp_rdy,
    output logic [15:0] resp_c,
    output logic        resp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_GAP  = 3'd2,
        S_RD   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_cyc;
    logic             r_stb;
    logic             r_we;
    logic [31:0]      r_dat_o;
    logic             r_resp_val;
    logic [15:0]      r_resp_c;
    logic             r_resp_err;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_nxt;
    logic             w_cyc_nxt;
    logic             w_stb_nxt;
    logic             w_we_nxt;
    logic [31:0]      w_dat_o_nxt;
    logic             w_resp_val_nxt;
    logic [15:0]      w_resp_c_nxt;
    logic             w_resp_err_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_expired;

    // Only the low half of the read data carries the result.
    logic w_unused_dat_hi;
    assign w_unused_dat_hi = ^wbm_dat_i[31:16];

    assign w_expired = (r_cnt == CNT_LAST);

    assign req_rdy   = (r_state == S_IDLE) & reset;
    assign resp_val  = r_resp_val;
    assign resp_c    = r_resp_c;
    assign resp_err  = r_resp_err;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = 4'hF;
    assign wbm_adr_o = GCD_ADDR;
    assign wbm_dat_o = r_dat_o;

    // Next-state and next-output decode. An ack always wins over timeout expiry.
    always_comb begin
        w_state_nxt    = r_state;
        w_cyc_nxt      = r_cyc;
        w_stb_nxt      = r_stb;
        w_we_nxt       = r_we;
        w_dat_o_nxt    = r_dat_o;
        w_resp_val_nxt = r_resp_val;
        w_resp_c_nxt   = r_resp_c;
        w_resp_err_nxt = r_resp_err;
        w_cnt_nxt      = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req_val) begin
                    w_dat_o_nxt = {req_a, req_b};
                    w_cyc_nxt   = 1'b1;
                    w_stb_nxt   = 1'b1;
                    w_we_nxt    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WR;
                end
            end
            S_WR: begin
                if (wbm_ack_i) begin
                    w_cyc_nxt   = 1'b0;
                    w_stb_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_state_nxt = S_GAP;
                end else if (w_expired) begin
                    w_cyc_nxt      = 1'b0;
                    w_stb_nxt      = 1'b0;
                    w_we_nxt       = 1'b0;
                    w_resp_c_nxt   = 16'd0;
                    w_resp_err_nxt = 1'b1;
                    w_resp_val_nxt = 1'b1;
                    w_state_nxt    = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                w_cyc_nxt   = 1'b1;
                w_stb_nxt   = 1'b1;
                w_we_nxt    = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_RD;
            end
            S_RD: begin
                if (wbm_ack_i) begin
                    w_cyc_nxt      = 1'b0;
                    w_stb_nxt      = 1'b0;
                    w_resp_c_nxt   = wbm_dat_i[15:0];
                    w_resp_err_nxt = 1'b0;
                    w_resp_val_nxt = 1'b1;
                    w_state_nxt    = S_RESP;
                end else if (w_expired) begin
                    w_cyc_nxt      = 1'b0;
                    w_stb_nxt      = 1'b0;
                    w_resp_c_nxt   = 16'd0;
                    w_resp_err_nxt = 1'b1;
                    w_resp_val_nxt = 1'b1;
                    w_state_nxt    = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RESP: begin
                if (resp_rdy) begin
                    w_resp_val_nxt = 1'b0;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: begin
                w_cyc_nxt   = 1'b0;
                w_stb_nxt   = 1'b0;
                w_we_nxt    = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs. Reset abandons any bus cycle in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_dat_o    <= 32'd0;
            r_resp_val <= 1'b0;
            r_resp_c   <= 16'd0;
            r_resp_err <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cyc      <= w_cyc_nxt;
            r_stb      <= w_stb_nxt;
            r_we       <= w_we_nxt;
            r_dat_o    <= w_dat_o_nxt;
            r_resp_val <= w_resp_val_nxt;
            r_resp_c   <= w_resp_c_nxt;
            r_resp_err <= w_resp_err_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_wb_gcd_initiator.sv
// Directed testbench for wb_gcd_initiator, with a behavioural GCD slave.
module tb_wb_gcd_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        resp_val;
    logic        resp_rdy;
    logic [15:0] resp_c;
    logic        resp_err;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack;

    int n_vec = 0;
    int n_bad = 0;

    // Slave model knobs.
    int          s_wait_cfg = 0;
    bit          s_never    = 1'b0;
    bit          s_force    = 1'b0;
    bit          s_rand_dat = 1'b0;
    logic [31:0] s_rand     = 32'd0;
    int          s_cnt      = 0;
    logic [31:0] s_lat      = 32'd0;
    logic [15:0] s_junk     = 16'd0;

    always #5 clk = ~clk;

    wb_gcd_initiator #(
        .GCD_ADDR(32'h3000_0000),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_c(resp_c), .resp_err(resp_err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack)
    );

    function automatic logic [15:0] gcd16(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] t;
        a = x;
        b = y;
        for (int i = 0; i < 32; i++) begin
            if (b != 16'd0) begin
                t = a % b;
                a = b;
                b = t;
            end
        end
        return a;
    endfunction

    always_comb ack = s_force | (cyc & stb & !s_never & (s_cnt >= s_wait_cfg));
    always_comb dat_i = s_rand_dat ? s_rand : {s_junk, gcd16(s_lat[31:16], s_lat[15:0])};

    always @(posedge clk) begin
        if (cyc && stb && !ack) s_cnt <= s_cnt + 1;
        else                    s_cnt <= 0;
        if (cyc && stb && we && ack) s_lat <= dat_o;
        s_junk <= 16'($urandom);
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at 1ms, required finish");
        $fatal(1);
    end

    // Waits (bounded) for req_rdy at a negedge, then presents a request.
    task automatic do_req(input logic [15:0] a, input logic [15:0] b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            req_a   = a;
            req_b   = b;
            req_val = 1'b1;
        end
    endtask

    // Observes one transaction after acceptance until resp_val (bounded).
    task automatic capture(input logic [31:0] exp_dat, output int wr_len, output int gap_len,
                           output int rd_len, output int lat, output bit got,
                           output logic [15:0] c, output logic e,
                           output bit dat_bad, output bit bus_bad);
        wr_len = 0; gap_len = 0; rd_len = 0; lat = -1; got = 1'b0;
        c = 16'hxxxx; e = 1'bx; dat_bad = 1'b0; bus_bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 0) req_val = 1'b0;
            if (stb && we) begin
                wr_len++;
                if (dat_o !== exp_dat) dat_bad = 1'b1;
            end
            if (stb && (adr !== 32'h3000_0000 || sel !== 4'hF)) bus_bad = 1'b1;
            if (wr_len > 0 && rd_len == 0 && !cyc && !resp_val) gap_len++;
            if (stb && !we) rd_len++;
            if (resp_val) begin
                got = 1'b1; c = resp_c; e = resp_err; lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req_val = 1'b0; resp_rdy = 1'b1; req_a = 16'd0; req_b = 16'd0;
        s_rand_dat = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_force = 1'($urandom_range(0, 1));
            s_rand  = $urandom;
            @(negedge clk);
            n_vec++;
            if ({cyc, stb, we, resp_val, resp_err, req_rdy} !== 6'b0 || resp_c !== 16'd0 || dat_o !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_hold cyc%0d: cyc=%b stb=%b we=%b rv=%b err=%b rdy=%b c=%h dat=%h, required all 0",
                         i, cyc, stb, we, resp_val, resp_err, req_rdy, resp_c, dat_o);
            end
        end
        s_force = 1'b0; s_rand_dat = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (req_rdy !== 1'b1 || cyc !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: req_rdy=%b cyc=%b, required 1 0", req_rdy, cyc);
        end
    endtask

    task automatic test_write_read();
        int wl, gl, rl, lat; bit got, db, bb, ok; logic [15:0] c; logic e;
        s_wait_cfg = 2;
        do_req(16'd48, 16'd18, ok);
        n_vec++;
        if (!ok) begin n_bad++; $display("FAIL wr_rd_accept: req_rdy never high, required 1"); end
        capture(32'h0030_0012, wl, gl, rl, lat, got, c, e, db, bb);
        n_vec++;
        if (wl !== 3 || gl !== 1 || rl !== 3) begin
            n_bad++;
            $display("FAIL wr_rd_phases: wr=%0d gap=%0d rd=%0d, required 3 1 3", wl, gl, rl);
        end
        n_vec++;
        if (db || bb) begin
            n_bad++;
            $display("FAIL wr_rd_bus: dat_bad=%b bus_bad=%b, required 0 0 (dat_o 00300012)", db, bb);
        end
        n_vec++;
        if (!got || c !== 16'd6 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_rd_result: got=%b c=%0d err=%b, required 1 6 0", got, c, e);
        end
    endtask

    task automatic test_timeout();
        int wl, gl, rl, lat; bit got, db, bb, ok; logic [15:0] c; logic e;
        s_never = 1'b1;
        @(negedge clk);
        do_req(16'd10, 16'd4, ok);
        capture(32'h000A_0004, wl, gl, rl, lat, got, c, e, db, bb);
        n_vec++;
        if (wl !== 8 || rl !== 0) begin
            n_bad++;
            $display("FAIL timeout_stb: wr_cycles=%0d rd_cycles=%0d, required 8 0", wl, rl);
        end
        n_vec++;
        if (!got || c !== 16'd0 || e !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_resp: got=%b c=%0d err=%b, required 1 0 1", got, c, e);
        end
        s_never = 1'b0;
    endtask

    task automatic test_backpressure();
        int wl, gl, rl, lat; bit got, db, bb, ok; logic [15:0] c; logic e;
        @(negedge clk);
        resp_rdy = 1'b0; s_wait_cfg = 1;
        do_req(16'd35, 16'd21, ok);
        capture(32'h0023_0015, wl, gl, rl, lat, got, c, e, db, bb);
        n_vec++;
        if (!got || c !== 16'd7 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_result: got=%b c=%0d err=%b, required 1 7 0", got, c, e);
        end
        req_a = 16'd100; req_b = 16'd75; req_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (resp_val !== 1'b1 || resp_c !== 16'd7 || resp_err !== 1'b0 || req_rdy !== 1'b0 || cyc !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold cyc%0d: rv=%b c=%0d err=%b rdy=%b cyc=%b, required 1 7 0 0 0",
                         i, resp_val, resp_c, resp_err, req_rdy, cyc);
            end
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        n_vec++;
        if (resp_val !== 1'b0 || req_rdy !== 1'b1 || cyc !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_handshake: rv=%b rdy=%b cyc=%b, required 0 1 0", resp_val, req_rdy, cyc);
        end
        capture(32'h0064_004B, wl, gl, rl, lat, got, c, e, db, bb);
        n_vec++;
        if (!got || c !== 16'd25 || e !== 1'b0 || db) begin
            n_bad++;
            $display("FAIL bp_next: got=%b c=%0d err=%b dat_bad=%b, required 1 25 0 0", got, c, e, db);
        end
    endtask

    task automatic test_reset_mid();
        int wl, gl, rl, lat; bit got, db, bb, ok, seen, junk;
        logic [15:0] c; logic e;
        @(negedge clk);
        s_wait_cfg = 5;
        do_req(16'd12, 16'd8, ok);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) req_val = 1'b0;
            if (stb && !we) begin seen = 1'b1; break; end
        end
        n_vec++;
        if (!seen) begin n_bad++; $display("FAIL rstmid_read: read phase not reached, required read"); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (cyc !== 1'b0 || stb !== 1'b0 || resp_val !== 1'b0 || req_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_drop: cyc=%b stb=%b rv=%b rdy=%b, required 0 0 0 0", cyc, stb, resp_val, req_rdy);
        end
        reset = 1'b1;
        junk = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (resp_val || cyc) junk = 1'b1;
        end
        n_vec++;
        if (junk !== 1'b0 || req_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_quiet: activity=%b rdy=%b, required 0 1", junk, req_rdy);
        end
        s_wait_cfg = 0;
        do_req(16'd81, 16'd27, ok);
        capture(32'h0051_001B, wl, gl, rl, lat, got, c, e, db, bb);
        n_vec++;
        if (!got || c !== 16'd27 || e !== 1'b0 || lat !== 3 || wl !== 1 || gl !== 1 || rl !== 1) begin
            n_bad++;
            $display("FAIL rstmid_next: got=%b c=%0d err=%b lat=%0d wr=%0d gap=%0d rd=%0d, required 1 27 0 3 1 1 1",
                     got, c, e, lat, wl, gl, rl);
        end
    endtask

    task automatic test_back_to_back();
        int wl, gl, rl, lat; bit got, db, bb, ok; logic [15:0] c; logic e;
        logic [15:0] a, b, g, exp_c;
        @(negedge clk);
        s_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (req_rdy !== 1'b1 || cyc !== 1'b0 || resp_val !== 1'b0) begin
                n_bad++;
                $display("FAIL spurious_ack cyc%0d: rdy=%b cyc=%b rv=%b, required 1 0 0", i, req_rdy, cyc, resp_val);
            end
        end
        s_force = 1'b0;
        for (int k = 0; k < 100; k++) begin
            g = 16'($urandom_range(1, 255));
            a = 16'(g * 16'($urandom_range(1, 255)));
            b = 16'(g * 16'($urandom_range(1, 255)));
            exp_c = gcd16(a, b);
            s_wait_cfg = $urandom_range(0, 3);
            do_req(a, b, ok);
            capture({a, b}, wl, gl, rl, lat, got, c, e, db, bb);
            n_vec++;
            if (!ok || !got || c !== exp_c || e !== 1'b0 || db || bb || gl !== 1) begin
                n_bad++;
                $display("FAIL b2b #%0d a=%0d b=%0d: ok=%b got=%b c=%0d err=%b dat_bad=%b bus_bad=%b gap=%0d, required 1 1 %0d 0 0 0 1",
                         k, a, b, ok, got, c, e, db, bb, gl, exp_c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
